cache_port_sequencer: RTL

Sequences and shares one port of the dual-port preloaded cache SRAM between two requesters, for example the PE read path and the configuration/update path. It accepts block-burst reads and element-granular writes through valid/ready handshakes. Requesters are served round-robin. Element writes are performed as a read-modify-write of the full block, and a tagged response stream is returned. The block sits directly in front of one SRAM port (addr/we/din/dout) inside the cache.

---
 rtl/cache_port_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cache_port_sequencer.sv
// Shares one cache SRAM port between two round-robin requesters: block-burst reads and element read-modify-writes.
// Read beat i responds at accept+2+i, write ack at accept+3; requests stall (ready low) while an op runs, responses have no backpressure.
module cache_port_sequencer #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_EPB             = 2,
  parameter int WIDTH              = 128,
  parameter int DEPTH              = 64,
  parameter int LG_DEPTH           = 6,
  parameter int LG_BURST           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_0,
  output logic                     req_ready_0,
  input  logic                     req_write_0,
  input  logic [LG_DEPTH-1:0]      req_addr_0,
  input  logic [LG_BURST-1:0]      req_len_0,
  input  logic [LG_EPB-1:0]        req_elem_0,
  input  logic [ELEMENT_WIDTH-1:0] req_wdata_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_1,
  input  logic                     req_write_1,
  input  logic [LG_DEPTH-1:0]      req_addr_1,
  input  logic [LG_BURST-1:0]      req_len_1,
  input  logic [LG_EPB-1:0]        req_elem_1,
  input  logic [ELEMENT_WIDTH-1:0] req_wdata_1,
  output logic                     resp_valid,
  output logic                     resp_id,
  output logic                     resp_last,
  output logic [WIDTH-1:0]         resp_data,
  output logic [LG_DEPTH-1:0]      sram_addr,
  output logic                     sram_we,
  output logic [WIDTH-1:0]         sram_din,
  input  logic [WIDTH-1:0]         sram_dout
);

  typedef enum logic [1:0] {IDLE, BURST, RMW_RD, RMW_WR} state_t;

  typedef struct packed {
    logic                     id;
    logic                     write;
    logic [LG_DEPTH-1:0]      addr;
    logic [LG_BURST-1:0]      len;
    logic [LG_EPB-1:0]        elem;
    logic [ELEMENT_WIDTH-1:0] wdata;
  } req_t;

  state_t               state, state_nxt;
  req_t                 cur, req_sel;
  logic                 last;
  logic [LG_BURST-1:0]  beat;
  logic                 grant_id, accept;
  logic [LG_DEPTH-1:0]  addr_c;
  logic                 we_c, issue, issue_last, issue_wr;
  logic                 rsp_vld, rsp_id, rsp_last, rsp_wr;
  logic [WIDTH-1:0]     merged, merged_q;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    grant_id = (req_valid_0 && req_valid_1) ? ~last : req_valid_1;
    accept   = rst_n && (state == IDLE) && (req_valid_0 || req_valid_1);
    req_ready_0 = accept && !grant_id;
    req_ready_1 = accept && grant_id;
    req_sel.id = grant_id;
    if (grant_id) begin
      req_sel.write = req_write_1;
      req_sel.addr  = req_addr_1;
      req_sel.len   = req_len_1;
      req_sel.elem  = req_elem_1;
      req_sel.wdata = req_wdata_1;
    end else begin
      req_sel.write = req_write_0;
      req_sel.addr  = req_addr_0;
      req_sel.len   = req_len_0;
      req_sel.elem  = req_elem_0;
      req_sel.wdata = req_wdata_0;
    end
  end

  always_comb begin
    merged = sram_dout;
    for (int e = 0; e < ELEMENTS_PER_BLOCK; e++) begin
      if (cur.elem == LG_EPB'(e)) merged[e*ELEMENT_WIDTH +: ELEMENT_WIDTH] = cur.wdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_c     = '0;
    we_c       = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_sel.write ? RMW_RD : BURST;
      end
      BURST: begin
        addr_c     = LG_DEPTH'((int'(cur.addr) + int'(beat)) % DEPTH);
        issue      = 1'b1;
        issue_last = (beat == cur.len);
        if (issue_last) state_nxt = IDLE;
      end
      RMW_RD: begin
        addr_c    = cur.addr;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        addr_c     = cur.addr;
        we_c       = 1'b1;
        issue      = 1'b1;
        issue_last = 1'b1;
        issue_wr   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      last     <= 1'b1;
      beat     <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_last <= 1'b0;
      rsp_wr   <= 1'b0;
      merged_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur  <= req_sel;
        last <= grant_id;
        beat <= '0;
      end else if (state == BURST) begin
        beat <= beat + 1'b1;
      end
      // Response stage trails the SRAM address by exactly one cycle.
      rsp_vld  <= issue;
      rsp_id   <= cur.id;
      rsp_last <= issue_last;
      rsp_wr   <= issue_wr;
      if (issue_wr) merged_q <= merged;
    end
  end

  assign sram_addr  = rst_n ? addr_c : '0;
  assign sram_we    = rst_n && we_c;
  assign sram_din   = (rst_n && we_c) ? merged : '0;
  assign resp_valid = rst_n && rsp_vld;
  assign resp_id    = rst_n && rsp_id;
  assign resp_last  = rst_n && rsp_last;
  assign resp_data  = (rst_n && rsp_vld) ? (rsp_wr ? merged_q : sram_dout) : '0;

endmodule
